// File: rtl/pla_sweep_pkg.sv
// Shared types and defaults for the PLA autosymmetry sweeper.
// The state encoding and the default function width live here.
package pla_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_IN_DEFAULT = 5;

endpackage

// File: rtl/lin_check.sv
// Tests a single candidate translation a: high when tt[x] == tt[x ^ a]
// holds for every vector x of the captured truth table.
module lin_check
    import pla_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
) (
    input  logic [(1<<N_IN)-1:0] tt,
    input  logic [N_IN-1:0]      a,
    output logic                 match
);

    localparam int NV = 1 << N_IN;

    logic [NV-1:0] eq;

    genvar gi;
    generate
        for (gi = 0; gi < NV; gi++) begin : g_pair
            assign eq[gi] = (tt[gi] == tt[N_IN'(gi) ^ a]);
        end
    endgenerate

    assign match = &eq;

endmodule

// File: rtl/pla_autosym_sweeper.sv
// Drives every input vector into an external single-output function, captures
// its truth table, then finds the linear space of translations leaving it fixed.
module pla_autosym_sweeper
    import pla_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [N_IN-1:0]              x_out,
    input  logic                         y_in,
    output logic                         busy,
    output logic                         done,
    output logic [(1<<N_IN)-1:0]         tt,
    output logic [(1<<N_IN)-1:0]         lin_mask,
    output logic [$clog2(N_IN+1)-1:0]    auto_dim
);

    localparam int NV = 1 << N_IN;
    localparam int DW = $clog2(N_IN + 1);
    localparam int CW = N_IN + 1;

    state_t          state_reg;
    logic [N_IN-1:0] v_reg;
    logic [N_IN-1:0] a_reg;
    logic [NV-1:0]   tt_reg;
    logic [NV-1:0]   lin_mask_reg;
    logic [DW-1:0]   auto_dim_reg;
    logic            busy_reg;
    logic            done_reg;

    logic            match;
    logic [NV-1:0]   lin_mask_next;
    logic [CW-1:0]   pop_next;
    logic [DW-1:0]   dim_next;

    lin_check #(
        .N_IN (N_IN)
    ) u_lin_check (
        .tt    (tt_reg),
        .a     (a_reg),
        .match (match)
    );

    // The final candidate's verdict is folded in before its register write,
    // so auto_dim is already valid in the DONE cycle.
    always_comb begin
        lin_mask_next        = lin_mask_reg;
        lin_mask_next[a_reg] = match;
        pop_next             = '0;
        for (int i = 0; i < NV; i++) begin
            pop_next = pop_next + {{N_IN{1'b0}}, lin_mask_next[i]};
        end
        dim_next = '0;
        for (int i = 0; i <= N_IN; i++) begin
            if (pop_next == CW'(1 << i)) begin
                dim_next = DW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            v_reg        <= '0;
            a_reg        <= '0;
            tt_reg       <= '0;
            lin_mask_reg <= '0;
            auto_dim_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= SWEEP;
                        v_reg        <= '0;
                        tt_reg       <= '0;
                        lin_mask_reg <= '0;
                        auto_dim_reg <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                SWEEP: begin
                    tt_reg[v_reg] <= y_in;
                    if (&v_reg) begin
                        state_reg       <= CHECK;
                        v_reg           <= '0;
                        a_reg           <= N_IN'(1);
                        lin_mask_reg[0] <= 1'b1;
                    end else begin
                        v_reg <= v_reg + N_IN'(1);
                    end
                end
                CHECK: begin
                    lin_mask_reg[a_reg] <= match;
                    if (&a_reg) begin
                        state_reg    <= DONE;
                        a_reg        <= '0;
                        done_reg     <= 1'b1;
                        auto_dim_reg <= dim_next;
                    end else begin
                        a_reg <= a_reg + N_IN'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // The vector counter doubles as the driven input, held at zero outside SWEEP.
    assign x_out    = v_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign tt       = tt_reg;
    assign lin_mask = lin_mask_reg;
    assign auto_dim = auto_dim_reg;

endmodule

// File: tb/tb_pla_autosym_sweeper.sv
// Directed runs with hand-computed tables; a monitor pops expected results
// from a scoreboard queue whenever the sweeper pulses done.
module tb_pla_autosym_sweeper;

    localparam int N  = 5;
    localparam int NV = 32;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  x_out;
    logic          y_in;
    logic          busy;
    logic          done;
    logic [NV-1:0] tt;
    logic [NV-1:0] lin_mask;
    logic [DW-1:0] auto_dim;

    int func_sel = 0;
    int edge_cnt = 0;
    int checks   = 0;
    int passes   = 0;
    int dones    = 0;

    typedef struct {
        logic [NV-1:0] tt;
        logic [NV-1:0] lm;
        logic [DW-1:0] dim;
        int            s_edge;
        string         name;
    } exp_t;

    exp_t q[$];

    pla_autosym_sweeper #(
        .N_IN (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_out    (x_out),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .tt       (tt),
        .lin_mask (lin_mask),
        .auto_dim (auto_dim)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    always_comb begin
        case (func_sel)
            0:       y_in = x_out[0];
            1:       y_in = 1'b0;
            2:       y_in = x_out[0] ^ x_out[1];
            3:       y_in = &x_out;
            4:       y_in = x_out[4];
            default: y_in = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 at edge %0d expected no done", edge_cnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_tt"}, 64'(tt), 64'(e.tt));
                chk({e.name, "_lin_mask"}, 64'(lin_mask), 64'(e.lm));
                chk({e.name, "_auto_dim"}, 64'(auto_dim), 64'(e.dim));
                chk({e.name, "_latency"}, 64'(edge_cnt - e.s_edge + 1), 64'd64);
                $display("run %s: tt=%h lin_mask=%h auto_dim=%0d cycle=%0d",
                         e.name, tt, lin_mask, auto_dim, edge_cnt - e.s_edge + 1);
            end
        end
    end

    int   s_edge;
    exp_t last;

    task automatic issue(input int f, input string name, input logic [NV-1:0] e_tt,
                         input logic [NV-1:0] e_lm, input logic [DW-1:0] e_dim,
                         input bit expect_done);
        exp_t e;
        func_sel = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_edge = edge_cnt;
        chk({name, "_clear_tt"}, 64'(tt), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd1);
        if (expect_done) begin
            e.tt = e_tt; e.lm = e_lm; e.dim = e_dim; e.s_edge = s_edge; e.name = name;
            q.push_back(e);
            last = e;
        end
    endtask

    task automatic wait_done(input string name);
        int d0;
        int n;
        d0 = dones;
        n = 0;
        while (dones == d0 && n < 200) begin
            tick();
            n++;
        end
        if (dones == d0) begin
            checks++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
        end
    endtask

    task automatic run(input int f, input string name, input logic [NV-1:0] e_tt,
                       input logic [NV-1:0] e_lm, input logic [DW-1:0] e_dim);
        issue(f, name, e_tt, e_lm, e_dim, 1'b1);
        wait_done(name);
        repeat (3) tick();
        chk({name, "_hold_tt"}, 64'(tt), 64'(e_tt));
        chk({name, "_hold_dim"}, 64'(auto_dim), 64'(e_dim));
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        start = 1'b0;
        #12;
        chk("rst_x_out", 64'(x_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_tt", 64'(tt), 64'd0);
        chk("rst_lin_mask", 64'(lin_mask), 64'd0);
        chk("rst_auto_dim", 64'(auto_dim), 64'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        run(0, "f_x0",   32'hAAAAAAAA, 32'h55555555, 3'd4);
        run(1, "f_zero", 32'h00000000, 32'hFFFFFFFF, 3'd5);
        run(2, "f_xor",  32'h66666666, 32'h99999999, 3'd4);
        run(3, "f_and5", 32'h80000000, 32'h00000001, 3'd0);
        run(4, "f_x4",   32'hFFFF0000, 32'h0000FFFF, 3'd4);

        // Abort at cycle 40, then restart cleanly.
        issue(0, "abort", '0, '0, '0, 1'b0);
        repeat (39) tick();
        rst = 1'b1;
        #2;
        chk("abort_async_tt", 64'(tt), 64'd0);
        chk("abort_async_busy", 64'(busy), 64'd0);
        chk("abort_async_x_out", 64'(x_out), 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        run(0, "f_x0_after_rst", 32'hAAAAAAAA, 32'h55555555, 3'd4);

        // Starts at cycle 10 (busy) and cycle 64 (DONE) must be ignored.
        d0 = dones;
        issue(0, "f_x0_ignore", 32'hAAAAAAAA, 32'h55555555, 3'd4, 1'b1);
        repeat (9) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (edge_cnt < s_edge + 63) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore_busy_after_done", 64'(busy), 64'd0);
        repeat (70) tick();
        chk("ignore_busy_later", 64'(busy), 64'd0);
        chk("ignore_hold_tt", 64'(tt), 64'(last.tt));
        chk("ignore_one_done", 64'(dones - d0), 64'd1);

        chk("total_dones", 64'(dones), 64'd7);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
